ddr_load_scheduler: RTL

- Shares the single DDR load channel between the instruction cache and the data cache.
- Captures refill requests from both caches and rebases addresses to DDR space.
- Issues one refill burst at a time and routes the returned beats to the owning cache.
- Replaces combinational request/response steering with a registered FSM that tracks burst beats and guarantees instruction-fetch forward progress under heavy data traffic.

---
 rtl/ddr_load_scheduler_pkg.sv | 23 ++
 rtl/ddr_load_scheduler_request_slot.sv | 31 +++
 rtl/ddr_load_scheduler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ddr_load_scheduler_pkg.sv
// Shared types and constants for the DDR load-channel scheduler.
// The user memory base comes from the platform-wide USER_MEMORY_REGION_START define when present.
`ifndef USER_MEMORY_REGION_START
`define USER_MEMORY_REGION_START 32'h0000_0000
`endif

package ddr_load_scheduler_pkg;

  localparam logic [31:0] USER_REGION_BASE = `USER_MEMORY_REGION_START;

  localparam int DEFAULT_BURST_BEATS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } sched_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } requester_t;

endpackage

// File: rtl/ddr_load_scheduler_request_slot.sv
// One pending refill request (flag, line address, invalidate qualifier) for a single cache.
// A clear in the same cycle as a capture wins: that request was granted through the bypass path.
module ddr_load_scheduler_request_slot #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  capture_i,
    input  logic                  clear_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  inv_i,
    output logic                  pending_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  inv_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_o <= 1'b0;
            addr_o    <= '0;
            inv_o     <= 1'b0;
        end else if (clear_i) begin
            pending_o <= 1'b0;
        end else if (capture_i) begin
            pending_o <= 1'b1;
            addr_o    <= addr_i;
            inv_o     <= inv_i;
        end
    end

endmodule

// File: rtl/ddr_load_scheduler.sv
// Arbitrates icache/dcache refills onto the single DDR load channel, one burst at a time,
// and steers returned beats to the owning cache with a starvation guard for instruction fetch.
module ddr_load_scheduler
    import ddr_load_scheduler_pkg::*;
#(
    parameter int                     ADDR_WIDTH   = 32,
    parameter int                     DATA_WIDTH   = 32,
    parameter int                     BURST_BEATS  = DEFAULT_BURST_BEATS,
    parameter logic [ADDR_WIDTH-1:0]  REGION_BASE  = ADDR_WIDTH'(USER_REGION_BASE),
    parameter int                     STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  icache_req_i,
    input  logic [ADDR_WIDTH-1:0] icache_addr_i,
    input  logic                  icache_inv_i,
    output logic                  icache_valid_o,
    output logic [DATA_WIDTH-1:0] icache_data_o,
    output logic                  icache_stall_o,
    input  logic                  dcache_req_i,
    input  logic [ADDR_WIDTH-1:0] dcache_addr_i,
    input  logic                  dcache_inv_i,
    output logic                  dcache_valid_o,
    output logic [DATA_WIDTH-1:0] dcache_data_o,
    output logic                  dcache_stall_o,
    output logic                  ddr_req_o,
    output logic [ADDR_WIDTH-1:0] ddr_addr_o,
    output logic                  ddr_inv_o,
    input  logic                  ddr_ready_i,
    input  logic                  ddr_valid_i,
    input  logic [DATA_WIDTH-1:0] ddr_data_i,
    output logic                  instr_load_o,
    output logic                  spurious_o,
    output sched_state_t          state_o
);

    localparam int BW = $clog2(BURST_BEATS);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST_BEATS - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    sched_state_t state_q, state_d;
    requester_t   owner_q;
    logic [BW-1:0] beat_q;
    logic [SW-1:0] starve_q;
    logic grant_i, grant_d, last_beat;

    logic                  i_pend, d_pend, i_pinv, d_pinv;
    logic [ADDR_WIDTH-1:0] i_paddr, d_paddr;

    // A source is busy while it is pending or owns the burst in progress; new pulses are then dropped.
    logic serving, i_busy, d_busy, i_cand, d_cand;
    assign serving = (state_q == WAIT);
    assign i_busy  = i_pend | (serving && owner_q == ICACHE);
    assign d_busy  = d_pend | (serving && owner_q == DCACHE);
    assign i_cand  = i_pend | icache_req_i;
    assign d_cand  = d_pend | dcache_req_i;

    ddr_load_scheduler_request_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_islot (
        .clk_i(clk_i), .rst_i(rst_i),
        .capture_i(icache_req_i & ~i_busy), .clear_i(grant_i),
        .addr_i(icache_addr_i), .inv_i(icache_inv_i),
        .pending_o(i_pend), .addr_o(i_paddr), .inv_o(i_pinv)
    );

    ddr_load_scheduler_request_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_dslot (
        .clk_i(clk_i), .rst_i(rst_i),
        .capture_i(dcache_req_i & ~d_busy), .clear_i(grant_d),
        .addr_i(dcache_addr_i), .inv_i(dcache_inv_i),
        .pending_o(d_pend), .addr_o(d_paddr), .inv_o(d_pinv)
    );

    logic [ADDR_WIDTH-1:0] i_sel_addr, d_sel_addr;
    logic                  i_sel_inv, d_sel_inv;
    assign i_sel_addr = i_pend ? i_paddr : icache_addr_i;
    assign i_sel_inv  = i_pend ? i_pinv  : icache_inv_i;
    assign d_sel_addr = d_pend ? d_paddr : dcache_addr_i;
    assign d_sel_inv  = d_pend ? d_pinv  : dcache_inv_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        last_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (ddr_ready_i && (i_cand || d_cand)) begin
                    if (i_cand && (!d_cand || starve_q >= STARVE_MAX)) grant_i = 1'b1;
                    else                                               grant_d = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ddr_valid_i && beat_q == LAST_BEAT) begin
                    last_beat = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q    <= ICACHE;
            beat_q     <= '0;
            starve_q   <= '0;
            ddr_req_o  <= 1'b0;
            ddr_addr_o <= '0;
            ddr_inv_o  <= 1'b0;
            spurious_o <= 1'b0;
        end else begin
            ddr_req_o  <= grant_i | grant_d;
            spurious_o <= ddr_valid_i && !serving;
            if (grant_i) begin
                owner_q    <= ICACHE;
                ddr_addr_o <= i_sel_addr - REGION_BASE;
                ddr_inv_o  <= i_sel_inv;
            end else if (grant_d) begin
                owner_q    <= DCACHE;
                ddr_addr_o <= d_sel_addr - REGION_BASE;
                ddr_inv_o  <= d_sel_inv;
            end
            if (last_beat)                  beat_q <= '0;
            else if (serving && ddr_valid_i) beat_q <= beat_q + 1'b1;
            // Count dcache wins only while an instruction fetch is actually waiting.
            if (grant_i || !i_cand)                     starve_q <= '0;
            else if (grant_d && starve_q != STARVE_MAX) starve_q <= starve_q + 1'b1;
        end
    end

    assign icache_valid_o = serving && owner_q == ICACHE && ddr_valid_i;
    assign dcache_valid_o = serving && owner_q == DCACHE && ddr_valid_i;
    assign icache_data_o  = icache_valid_o ? ddr_data_i : '0;
    assign dcache_data_o  = dcache_valid_o ? ddr_data_i : '0;
    assign icache_stall_o = serving && owner_q == DCACHE;
    assign dcache_stall_o = serving && owner_q == ICACHE;
    assign instr_load_o   = serving && owner_q == ICACHE;
    assign state_o        = state_q;

endmodule
